// File: rtl/lab5_program_loader.sv
// Streams a program into the shared RAM, appends a zero terminator, then starts the controller.
// Latency: last word accepted at t -> written t+1, terminator t+2, start t+3; in_ready drops outside IDLE/LOAD.
module lab5_program_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_own,
  output logic                  start,
  input  logic                  ctrl_done,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  zero_seen,
  output logic                  error
);

  // Highest address a data word may occupy while still leaving room for the terminator.
  localparam logic [ADDR_WIDTH-1:0] LAST_DATA_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TERM,
    S_START,
    S_RUN,
    S_ERR
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    xfer;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    wr_addr    = ptr;
    // in_ready is gated by rst so every output reads 0 while reset is held.
    case (state)
      S_IDLE: begin
        in_ready = rst;
        wr_addr  = '0;
      end
      S_LOAD:  in_ready = rst;
      default: ;
    endcase
    xfer = in_valid && in_ready;
    case (state)
      S_IDLE, S_LOAD: begin
        if (xfer) begin
          if (in_last) begin
            next_state = S_TERM;
          end else if (wr_addr == LAST_DATA_ADDR) begin
            next_state = S_ERR;
          end else begin
            next_state = S_LOAD;
          end
        end
      end
      S_TERM:  next_state = S_START;
      S_START: next_state = S_RUN;
      S_RUN:   if (ctrl_done) next_state = S_IDLE;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr        <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_own    <= 1'b0;
      start      <= 1'b0;
      word_count <= '0;
      zero_seen  <= 1'b0;
      error      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      start  <= 1'b0;
      if (xfer) begin
        ram_we   <= 1'b1;
        ram_addr <= wr_addr;
        ram_din  <= in_data;
        ptr      <= wr_addr + 1'b1;
        if (state == S_IDLE) begin
          ram_own   <= 1'b1;
          zero_seen <= (in_data == '0);
        end else if (in_data == '0) begin
          zero_seen <= 1'b1;
        end
      end
      case (state)
        S_TERM: begin
          ram_we     <= 1'b1;
          ram_addr   <= ptr;
          ram_din    <= '0;
          word_count <= ptr;
        end
        S_START: begin
          start   <= 1'b1;
          ram_own <= 1'b0;
        end
        // The overflowing word is written with ownership still held; release afterwards.
        S_ERR: begin
          ram_own <= 1'b0;
          error   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab5_program_loader.sv
// Directed bench: expected RAM writes and start pulses come from a program-level model;
// a per-cycle monitor checks every write/start against it, plus literal spot checks.
module tb_lab5_program_loader;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          ctrl_done = 1'b0;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic          ram_own;
  logic          start;
  logic [AW-1:0] word_count;
  logic          zero_seen;
  logic          error;

  lab5_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_own(ram_own), .start(start), .ctrl_done(ctrl_done), .word_count(word_count),
    .zero_seen(zero_seen), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            term;
  } wr_t;

  int            checks = 0;
  int            errors = 0;
  wr_t           exp_wr[$];
  int            exp_start_wc[$];
  logic [DW-1:0] prog[$];
  bit            exp_zero;
  int            cyc = 0;
  int            last_term_cyc = -10;
  wr_t           w;
  int            wc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every start pulse must be predicted by the model.
  always @(negedge clk) begin
    cyc++;
    if (ram_we) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected (t=%0t)",
                 ram_addr, ram_din, $time);
      end else begin
        w = exp_wr.pop_front();
        chk("write_addr", 64'(ram_addr), 64'(w.addr));
        chk("write_data", 64'(ram_din), 64'(w.data));
        chk("write_own", 64'(ram_own), 64'(1));
        if (w.term) last_term_cyc = cyc;
      end
    end
    if (start) begin
      checks++;
      if (exp_start_wc.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: start=1, no start expected (t=%0t)", $time);
      end else begin
        wc = exp_start_wc.pop_front();
        chk("start_word_count", 64'(word_count), 64'(wc));
        chk("start_after_term", 64'(cyc - last_term_cyc), 64'(1));
        chk("start_writes_done", 64'(exp_wr.size()), 64'(0));
        chk("start_own_released", 64'(ram_own), 64'(0));
      end
    end
  end

  // Program-level model: data words at 0..n-1, terminator at n when the program is closed.
  task automatic model_program(input bit has_last);
    exp_zero = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      exp_wr.push_back('{addr: AW'(i), data: prog[i], term: 1'b0});
      if (prog[i] == '0) exp_zero = 1'b1;
    end
    if (has_last) begin
      exp_wr.push_back('{addr: AW'(prog.size()), data: '0, term: 1'b1});
      exp_start_wc.push_back(prog.size());
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    chk("in_ready_on_send", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_program(input bit has_last, input bit toggle);
    for (int i = 0; i < prog.size(); i++) begin
      send_word(prog[i], has_last && (i == prog.size() - 1));
      if (toggle && i != prog.size() - 1) idle(1);
    end
  endtask

  task automatic wait_start(input int exp_edges, input string name);
    int k;
    k = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start) begin
        k = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, 64'(k), 64'(exp_edges));
    @(posedge clk); #1;
  endtask

  task automatic finish_run();
    chk("run_in_ready", 64'(in_ready), 64'(0));
    ctrl_done = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0;
    chk("idle_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({name, "_ram_we"}, 64'(ram_we), 64'(0));
    chk({name, "_ram_addr"}, 64'(ram_addr), 64'(0));
    chk({name, "_ram_din"}, 64'(ram_din), 64'(0));
    chk({name, "_ram_own"}, 64'(ram_own), 64'(0));
    chk({name, "_start"}, 64'(start), 64'(0));
    chk({name, "_word_count"}, 64'(word_count), 64'(0));
    chk({name, "_zero_seen"}, 64'(zero_seen), 64'(0));
    chk({name, "_error"}, 64'(error), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    // Three words, valid held high
    prog = '{32'h11, 32'h22, 32'h33};
    model_program(1'b1);
    drive_program(1'b1, 1'b0);
    wait_start(2, "latency_held");
    chk("wc_held", 64'(word_count), 64'(3));
    chk("zero_seen_held", 64'(zero_seen), 64'(exp_zero));
    chk("own_in_run", 64'(ram_own), 64'(0));
    finish_run();

    // Same program with valid toggling
    model_program(1'b1);
    drive_program(1'b1, 1'b1);
    wait_start(2, "latency_toggle");
    chk("wc_toggle", 64'(word_count), 64'(3));

    // Stay in RUN with valid asserted: no acceptance, no writes
    in_valid = 1'b1;
    in_data  = 32'h0000_0BAD;
    in_last  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("run_blocks_input", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    prog = '{32'h99};
    model_program(1'b1);
    in_data   = 32'h99;
    in_last   = 1'b1;
    ctrl_done = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0;
    chk("ready_after_done", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_start(2, "latency_one_word");
    chk("wc_one_word", 64'(word_count), 64'(1));
    finish_run();

    // Zero data word inside the program
    prog = '{32'h5, 32'h0, 32'h7};
    model_program(1'b1);
    drive_program(1'b1, 1'b0);
    wait_start(2, "latency_zero");
    chk("zero_seen_set", 64'(zero_seen), 64'(exp_zero));
    chk("zero_seen_literal", 64'(zero_seen), 64'(1));
    chk("wc_zero", 64'(word_count), 64'(3));
    finish_run();

    // Reset in the middle of a four-word program
    prog = '{32'h0, 32'hA2};
    model_program(1'b0);
    drive_program(1'b0, 1'b0);
    chk("zero_seen_before_rst", 64'(zero_seen), 64'(1));
    in_valid = 1'b1;
    in_data  = 32'hA3;
    in_last  = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midload_reset");
    rst      = 1'b1;
    in_valid = 1'b0;
    idle(8);
    chk("no_start_after_abort", 64'(start), 64'(0));

    // Full capacity with terminator in the last slot
    prog.delete();
    for (int i = 0; i < DEPTH - 1; i++) prog.push_back(32'h100 + 32'(i));
    model_program(1'b1);
    drive_program(1'b1, 1'b0);
    wait_start(2, "latency_full");
    chk("wc_full", 64'(word_count), 64'(15));
    chk("error_full_ok", 64'(error), 64'(0));
    finish_run();

    // Overflow: fifteen words without in_last
    model_program(1'b0);
    drive_program(1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hF00D;
    in_last  = 1'b0;
    idle(5);
    chk("overflow_error", 64'(error), 64'(1));
    chk("overflow_in_ready", 64'(in_ready), 64'(0));
    chk("overflow_own", 64'(ram_own), 64'(0));
    in_valid = 1'b0;
    idle(3);
    chk("overflow_error_sticky", 64'(error), 64'(1));

    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("error_cleared", 64'(error), 64'(0));
    chk("ready_after_final_reset", 64'(in_ready), 64'(1));

    chk("writes_outstanding", 64'(exp_wr.size()), 64'(0));
    chk("starts_outstanding", 64'(exp_start_wc.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
